// File: rtl/kernel_transform_pkg.sv
// Shared types and helpers for the kernel_transform block.
// KERNEL_TRANSFORM_PINGPONG_EN selects two kernel buffers instead of one.
package kernel_transform_pkg;

  typedef enum logic [2:0] {
    XF_IDENT     = 3'd0,
    XF_ROT90     = 3'd1,
    XF_ROT180    = 3'd2,
    XF_ROT270    = 3'd3,
    XF_HFLIP     = 3'd4,
    XF_VFLIP     = 3'd5,
    XF_TRANS     = 3'd6,
    XF_ANTITRANS = 3'd7
  } xform_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

`ifdef KERNEL_TRANSFORM_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  // Row/column counter width; never narrower than one bit.
  function automatic int idx_w(input int size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/kernel_transform_if.sv
// Stream interface of kernel_transform: input element stream, output element stream and status.
interface kernel_transform_if #(
  parameter int DATA_W = 32
);
  logic [2:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/kernel_xform_addr.sv
// Maps an output position (row, col) to the source position of the input kernel
// for the selected geometric transform. Purely combinational.
module kernel_xform_addr
  import kernel_transform_pkg::*;
#(
  parameter int SIZE = 5
) (
  input  xform_mode_t               mode_i,
  input  logic [idx_w(SIZE)-1:0]    rdRow_i,
  input  logic [idx_w(SIZE)-1:0]    rdCol_i,
  output logic [idx_w(SIZE)-1:0]    srcRow_o,
  output logic [idx_w(SIZE)-1:0]    srcCol_o
);

  localparam int W = idx_w(SIZE);
  localparam logic [W-1:0] MAX_IDX = W'(SIZE - 1);

  always_comb begin
    srcRow_o = rdRow_i;
    srcCol_o = rdCol_i;
    case (mode_i)
      XF_IDENT:     begin srcRow_o = rdRow_i;           srcCol_o = rdCol_i;           end
      XF_ROT90:     begin srcRow_o = MAX_IDX - rdCol_i; srcCol_o = rdRow_i;           end
      XF_ROT180:    begin srcRow_o = MAX_IDX - rdRow_i; srcCol_o = MAX_IDX - rdCol_i; end
      XF_ROT270:    begin srcRow_o = rdCol_i;           srcCol_o = MAX_IDX - rdRow_i; end
      XF_HFLIP:     begin srcRow_o = rdRow_i;           srcCol_o = MAX_IDX - rdCol_i; end
      XF_VFLIP:     begin srcRow_o = MAX_IDX - rdRow_i; srcCol_o = rdCol_i;           end
      XF_TRANS:     begin srcRow_o = rdCol_i;           srcCol_o = rdRow_i;           end
      XF_ANTITRANS: begin srcRow_o = MAX_IDX - rdCol_i; srcCol_o = MAX_IDX - rdRow_i; end
      default:      begin srcRow_o = rdRow_i;           srcCol_o = rdCol_i;           end
    endcase
  end

endmodule

// File: rtl/kernel_transform.sv
// Buffers one SIZE x SIZE kernel and re-emits it row-major under a geometric transform.
// KERNEL_TRANSFORM_PINGPONG_EN adds a second bank so loading overlaps emission.
module kernel_transform
  import kernel_transform_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SIZE   = 5
) (
  input  logic                clk,
  input  logic                reset,
  kernel_transform_if.slave   bus
);

  localparam int W     = idx_w(SIZE);
  localparam int FRAME = SIZE * SIZE;
  localparam int AW    = $clog2(NUM_BANKS * FRAME);
  localparam logic [W-1:0] MAX_IDX = W'(SIZE - 1);

  logic [DATA_W-1:0] mem_q [NUM_BANKS*FRAME];

  state_t            wrState_q, rdState_q;
  logic [W-1:0]      wrRow_q, wrCol_q, rdRow_q, rdCol_q;
  logic              wrBank_q, rdBank_q;
  logic [1:0]        full_q;
  xform_mode_t       bankMode_q [2];
  logic [DATA_W-1:0] outData_q;
  logic              outLast_q;

  logic              emitting, inHs, outHs, wrLast, wrDone;
  logic              finishing, advance, startEmit;
  logic              candBank, candReady, fetchBank, fetchLast, bypass;
  logic [W-1:0]      nextRow, nextCol, fetchRow, fetchCol, srcRow, srcCol;
  xform_mode_t       fetchMode;
  logic [DATA_W-1:0] fetchData;

  function automatic logic [AW-1:0] memAddr(input logic bank, input logic [W-1:0] row,
                                            input logic [W-1:0] col);
    return AW'((int'(bank) * FRAME) + (int'(row) * SIZE) + int'(col));
  endfunction

  function automatic logic otherBank(input logic b);
    return (NUM_BANKS == 2) ? ~b : 1'b0;
  endfunction

  assign emitting  = (rdState_q == ST_EMIT);
  assign inHs      = bus.in_valid && !full_q[wrBank_q];
  assign wrLast    = (wrRow_q == MAX_IDX) && (wrCol_q == MAX_IDX);
  assign wrDone    = inHs && wrLast;
  assign outHs     = emitting && bus.out_ready;
  assign finishing = outHs && outLast_q;
  assign advance   = outHs && !outLast_q;

  // The next frame to emit may be completing on this very edge, so it counts as ready.
  assign candBank  = emitting ? otherBank(rdBank_q) : rdBank_q;
  assign candReady = (full_q[candBank] && !(finishing && (candBank == rdBank_q)))
                   || (wrDone && (wrBank_q == candBank));
  assign startEmit = (!emitting || finishing) && candReady;

  assign nextCol = (rdCol_q == MAX_IDX) ? '0 : rdCol_q + 1'b1;
  assign nextRow = (rdCol_q == MAX_IDX) ? rdRow_q + 1'b1 : rdRow_q;

  always_comb begin
    fetchRow  = '0;
    fetchCol  = '0;
    fetchBank = candBank;
    if (advance) begin
      fetchRow  = nextRow;
      fetchCol  = nextCol;
      fetchBank = rdBank_q;
    end
  end

  assign fetchMode = bankMode_q[fetchBank];
  assign fetchLast = (fetchRow == MAX_IDX) && (fetchCol == MAX_IDX);

  kernel_xform_addr #(.SIZE(SIZE)) u_addr (
    .mode_i   (fetchMode),
    .rdRow_i  (fetchRow),
    .rdCol_i  (fetchCol),
    .srcRow_o (srcRow),
    .srcCol_o (srcCol)
  );

  // The last input element is not in the buffer yet when the first output may need it.
  assign bypass    = wrDone && (fetchBank == wrBank_q) && (srcRow == MAX_IDX) && (srcCol == MAX_IDX);
  assign fetchData = bypass ? bus.in_data : mem_q[memAddr(fetchBank, srcRow, srcCol)];

  always_ff @(posedge clk) begin
    if (!reset && inHs) begin
      mem_q[memAddr(wrBank_q, wrRow_q, wrCol_q)] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrState_q     <= ST_IDLE;
      rdState_q     <= ST_IDLE;
      wrRow_q       <= '0;
      wrCol_q       <= '0;
      rdRow_q       <= '0;
      rdCol_q       <= '0;
      wrBank_q      <= 1'b0;
      rdBank_q      <= 1'b0;
      full_q        <= '0;
      bankMode_q[0] <= XF_IDENT;
      bankMode_q[1] <= XF_IDENT;
      outData_q     <= '0;
      outLast_q     <= 1'b0;
    end else begin
      if (inHs) begin
        if (wrState_q == ST_IDLE) begin
          bankMode_q[wrBank_q] <= xform_mode_t'(bus.mode);
        end
        if (wrLast) begin
          wrRow_q          <= '0;
          wrCol_q          <= '0;
          full_q[wrBank_q] <= 1'b1;
          wrBank_q         <= otherBank(wrBank_q);
          wrState_q        <= ST_IDLE;
        end else begin
          wrState_q <= ST_LOAD;
          if (wrCol_q == MAX_IDX) begin
            wrCol_q <= '0;
            wrRow_q <= wrRow_q + 1'b1;
          end else begin
            wrCol_q <= wrCol_q + 1'b1;
          end
        end
      end

      if (finishing) begin
        full_q[rdBank_q] <= 1'b0;
        rdState_q        <= ST_IDLE;
        outLast_q        <= 1'b0;
      end

      if (startEmit) begin
        rdState_q <= ST_EMIT;
        rdBank_q  <= candBank;
        rdRow_q   <= '0;
        rdCol_q   <= '0;
        outData_q <= fetchData;
        outLast_q <= fetchLast;
      end else if (advance) begin
        rdRow_q   <= nextRow;
        rdCol_q   <= nextCol;
        outData_q <= fetchData;
        outLast_q <= fetchLast;
      end
    end
  end

  assign bus.in_ready  = !full_q[wrBank_q];
  assign bus.out_valid = emitting;
  assign bus.out_data  = outData_q;
  assign bus.out_last  = outLast_q;
  assign bus.busy      = (wrState_q != ST_IDLE) || emitting;

endmodule

// File: tb/tb_kernel_transform.sv
// Self-checking bench for kernel_transform (SIZE=3): random and directed frames,
// scoreboard fed by a matrix-operation reference model.
module tb_kernel_transform;
  import kernel_transform_pkg::*;

  localparam int SIZE   = 3;
  localparam int DATA_W = 32;
  localparam int FRAME  = SIZE * SIZE;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  kernel_transform_if #(.DATA_W(DATA_W)) bus();

  kernel_transform #(.DATA_W(DATA_W), .SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        expQ[$];
  int          nCompared   = 0;
  int          nMismatched = 0;
  int          readyMode   = 0;
  int          patIdx      = 0;
  logic [31:0] frameIn [FRAME];
  logic [31:0] refMat  [SIZE][SIZE];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    nCompared++;
    if (act !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, want);
    end
  endtask

  task automatic reportTimeout(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Primitive matrix operations: 0 transpose, 1 horizontal flip, 2 vertical flip.
  function automatic void applyOp(input int op);
    logic [31:0] tmp [SIZE][SIZE];
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        case (op)
          0:       tmp[r][c] = refMat[c][r];
          1:       tmp[r][c] = refMat[r][SIZE-1-c];
          default: tmp[r][c] = refMat[SIZE-1-r][c];
        endcase
      end
    end
    refMat = tmp;
  endfunction

  function automatic void pushExpected(input int m);
    exp_t e;
    for (int i = 0; i < FRAME; i++) refMat[i / SIZE][i % SIZE] = frameIn[i];
    case (m)
      1: begin applyOp(0); applyOp(1); end
      2: begin applyOp(1); applyOp(2); end
      3: begin applyOp(0); applyOp(2); end
      4: applyOp(1);
      5: applyOp(2);
      6: applyOp(0);
      7: begin applyOp(0); applyOp(1); applyOp(2); end
      default: ;
    endcase
    for (int i = 0; i < FRAME; i++) begin
      e.data = refMat[i / SIZE][i % SIZE];
      e.last = (i == FRAME - 1);
      expQ.push_back(e);
    end
  endfunction

  task automatic applyStimulus(input int m, input int nElem, input int switchAt, input int switchMode,
                               input int maxGap, input bit keepValid, input bit checkLat);
    bit accepted;
    int tries;
    for (int i = 0; i < nElem; i++) begin
      repeat ($urandom_range(maxGap, 0)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      accepted = 1'b0;
      tries    = 0;
      while (!accepted && tries < 500) begin
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = frameIn[i];
        bus.mode     = 3'((switchAt >= 0 && i >= switchAt) ? switchMode : m);
        accepted     = bus.in_ready;
        @(posedge clk);
        tries++;
      end
      if (!accepted) begin
        reportTimeout("input accept");
        return;
      end
    end
    if (nElem == FRAME) pushExpected(m);
    if (!keepValid) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (checkLat) checkOutput("first out_valid latency", bus.out_valid, 1);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() > 0) begin
      reportTimeout("drain");
      expQ.delete();
    end
    @(negedge clk);
    checkOutput("busy after drain", bus.busy, 0);
    checkOutput("out_valid after drain", bus.out_valid, 0);
  endtask

  function automatic void loadCount(input int base);
    for (int i = 0; i < FRAME; i++) frameIn[i] = 32'(base + i);
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (readyMode)
      0:       bus.out_ready = 1'b1;
      1:       begin bus.out_ready = (patIdx % 3 == 0); patIdx++; end
      default: bus.out_ready = 1'($urandom_range(1, 0));
    endcase
  end

  // Monitor: the presented element is always the scoreboard head; it is consumed on handshake.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
`ifndef KERNEL_TRANSFORM_PINGPONG_EN
      checkOutput("in_ready during emit", bus.in_ready, 0);
`endif
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected output: got 0x%0h, wanted no output", bus.out_data);
      end else begin
        checkOutput("out_data", bus.out_data, expQ[0].data);
        checkOutput("out_last", 32'(bus.out_last), 32'(expQ[0].last));
        if (bus.out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset out_last", bus.out_last, 0);
    checkOutput("reset out_data", bus.out_data, 0);
    checkOutput("reset in_ready", bus.in_ready, 1);
    reset = 1'b0;

    $display("[TB] rot180 with latency check");
    loadCount(0);
    applyStimulus(2, FRAME, -1, 0, 0, 0, 1);
    waitDrain();

    $display("[TB] rot90, transpose, hflip");
    foreach (frameIn[i]) frameIn[i] = 32'(i);
    applyStimulus(1, FRAME, -1, 0, 0, 0, 1);
    waitDrain();
    applyStimulus(6, FRAME, -1, 0, 0, 0, 1);
    waitDrain();
    applyStimulus(4, FRAME, -1, 0, 0, 0, 1);
    waitDrain();

    $display("[TB] backpressure, identity");
    readyMode = 1;
    patIdx    = 0;
    applyStimulus(0, FRAME, -1, 0, 0, 0, 0);
    waitDrain();
    readyMode = 0;

    $display("[TB] mode change mid-frame");
    applyStimulus(2, FRAME, 4, 0, 0, 0, 0);
    waitDrain();

    $display("[TB] reset mid-frame");
    applyStimulus(0, 5, -1, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("post-reset busy", bus.busy, 0);
    checkOutput("post-reset out_valid", bus.out_valid, 0);
    checkOutput("post-reset in_ready", bus.in_ready, 1);
    loadCount(10);
    applyStimulus(0, FRAME, -1, 0, 0, 0, 1);
    waitDrain();

    $display("[TB] random frames");
    readyMode = 2;
    for (int f = 0; f < 8; f++) begin
      foreach (frameIn[i]) frameIn[i] = $urandom();
      applyStimulus(int'($urandom_range(7, 0)), FRAME, -1, 0, 2, 0, 0);
    end
    waitDrain();
    readyMode = 0;
    @(negedge clk);

`ifdef KERNEL_TRANSFORM_PINGPONG_EN
    $display("[TB] back-to-back frames");
    fork
      begin
        loadCount(100);
        applyStimulus(3, FRAME, -1, 0, 0, 1, 0);
        loadCount(200);
        applyStimulus(7, FRAME, -1, 0, 0, 0, 0);
      end
      begin
        int n = 0;
        while (!bus.out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (!bus.out_valid) reportTimeout("back-to-back first out_valid");
        else begin
          for (int i = 0; i < 2 * FRAME; i++) begin
            checkOutput("b2b out_valid", bus.out_valid, 1);
            checkOutput("b2b out_last", bus.out_last, (i == FRAME - 1 || i == 2 * FRAME - 1) ? 1 : 0);
            if (i < FRAME) checkOutput("b2b in_ready", bus.in_ready, 1);
            @(negedge clk);
          end
        end
      end
    join
    waitDrain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/kernel_transform.md
Name: kernel_transform

Overview:
- Streaming, parametrised successor of the fixed 180° kernel flip.
- Accepts one SIZE×SIZE kernel, row-major, one element per accepted beat.
- Buffers the whole kernel, then emits it row-major under a selectable geometric transform: identity, 90/180/270° rotation, flips, transposes.
- Sits between the weight loader and the FFT/convolution stage.

Parameters:
- DATA_W, 32, element width in bits.
- SIZE, 5, kernel edge length (≥2); frame = SIZE*SIZE elements.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mode  in  3  transform select, sampled with the first element of a frame
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  DATA_W  input element, row-major
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  transformed element, row-major
- out_last  out  1  high with the final element of a frame
- busy  out  1  frame in progress (not IDLE)

Behaviour:
- Reset (sync, active-high, priority over all else): state=IDLE, counters=0, out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1. Buffer contents are don't-care.
- Handshake: transfer when valid&&ready on the same edge. out_valid/out_data/out_last stay stable while out_valid&&!out_ready. in_valid may drop between beats.
- FSM states:
  - IDLE: in_ready=1. The first accepted beat writes buf[0][0], latches mode, goes to LOAD (or EMIT if SIZE*SIZE==1, excluded by SIZE≥2).
  - LOAD: in_ready=1. Each beat writes buf[wr_r][wr_c]; the column counter wraps at SIZE-1 and increments the row. The beat at index SIZE*SIZE-1 moves to EMIT.
  - EMIT: in_ready=0. The output register is loaded with buf[src_r][src_c] for output position (rd_r,rd_c). The read position advances on each output handshake. The handshake on element SIZE*SIZE-1 (out_last=1) returns to IDLE, with out_valid=0 the next cycle unless PINGPONG_EN applies.
- Latency: out_valid rises on the 1st cycle after the last input handshake. With out_ready held high, a full frame drains in SIZE*SIZE consecutive cycles.
- Mode mapping, out[r][c] = in[src_r][src_c], S=SIZE:
  - 0 identity: (r,c)
  - 1 rot90 CW: (S-1-c, r)
  - 2 rot180: (S-1-r, S-1-c)
  - 3 rot270 CW: (c, S-1-r)
  - 4 hflip: (r, S-1-c)
  - 5 vflip: (S-1-r, c)
  - 6 transpose: (c, r)
  - 7 anti-transpose: (S-1-c, S-1-r)
- Mode changes mid-frame are ignored; the latched mode governs the whole frame.
- Counters are $clog2(SIZE) bits wide; wrap is explicit compare-to-SIZE-1, never relying on a power-of-2 overflow.
- busy=1 in LOAD and EMIT.
- Reset mid-frame drops the partial frame and any pending output; there is no out_last for the dropped frame.

Optional Feature:
- Macro: KERNEL_TRANSFORM_PINGPONG_EN.
- Defined:
  - Two buffers with a write bank and a read bank.
  - in_ready=1 while loading frame N+1 during EMIT of frame N, provided the write bank is free.
  - A complete loaded bank waits if the read bank is still emitting; in_ready=0 while both banks are full.
  - Each bank stores its own latched mode.
  - Back-to-back frames emit with no idle cycle between frames: frame N+1's first element follows frame N's last handshake on the next cycle.
- Undefined: single buffer; in_ready=0 throughout EMIT, as described above.

Decomposition:
- Package kernel_transform_pkg holds:
  - typedef enum logic [2:0] xform_mode_t (XF_IDENT … XF_ANTITRANS)
  - state enum (ST_IDLE, ST_LOAD, ST_EMIT)
  - function idx_w(size)
- Sub-module kernel_xform_addr: purely combinational (mode, rd_r, rd_c) → (src_r, src_c), parametrised by SIZE. It is shared by both banks and unit-testable alone.

Test Plan:
- SIZE=3, mode=2, inputs 0..8, out_ready=1 → outputs 8,7,6,5,4,3,2,1,0; out_last only on value 0; first out_valid 1 cycle after input 8 accepted.
- SIZE=3, mode=1, inputs 0..8 → 6,3,0,7,4,1,8,5,2. mode=6 → 0,3,6,1,4,7,2,5,8. mode=4 → 2,1,0,5,4,3,8,7,6.
- Backpressure: mode=0, out_ready toggled 1,0,0,1… → out_data held stable while stalled; sequence 0..8 intact, no duplicates or drops; in_ready=0 during EMIT (macro off).
- Mode change at element 4 (latched mode=2, new mode=0) → frame still emitted as rot180.
- Reset asserted after 5 of 9 inputs → next cycle busy=0, out_valid=0, in_ready=1; new frame 10..18, mode=0 → outputs 10..18 exactly.
- KERNEL_TRANSFORM_PINGPONG_EN, two frames streamed back-to-back with out_ready=1 → in_ready stays high through frame 1 EMIT; out_valid continuous for 18 cycles; out_last at cycles 9 and 18.
